// File: rtl/sram_port_arbiter.sv
// Shares one single-port, 1-cycle-latency SRAM between fetch, load and store; partial stores are read-modify-write.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed STORE > LOAD > FETCH priority instead of round-robin.
module sram_port_arbiter #(
   parameter int XLEN       = 64,
   parameter int ADDR_WIDTH = 20
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  fetch_addr_valid,
   output logic                  fetch_addr_ready,
   input  logic [XLEN-1:0]       fetch_addr,
   output logic                  fetch_data_valid,
   output logic [31:0]           fetch_data,
   input  logic                  load_a_valid,
   output logic                  load_a_ready,
   input  logic [XLEN-1:0]       load_a_addr,
   output logic                  load_d_valid,
   output logic [31:0]           load_d_data,
   input  logic                  wvalid,
   output logic                  wready,
   input  logic [XLEN-1:0]       waddr,
   input  logic [31:0]           wdata,
   input  logic [3:0]            wstrb,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [31:0]           sram_wdata,
   input  logic [31:0]           sram_rdata
);

   typedef enum logic {IDLE, RMW_WR} state_t;

   localparam logic [1:0] REQ_FETCH = 2'd0;
   localparam logic [1:0] REQ_LOAD  = 2'd1;
   localparam logic [1:0] REQ_STORE = 2'd2;

   state_t                state_q, state_d;
   logic                  fetch_vld_q, fetch_vld_d;
   logic                  load_vld_q, load_vld_d;
   logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
   logic [31:0]           rmw_wdata_q, rmw_wdata_d;
   logic [3:0]            rmw_strb_q, rmw_strb_d;
   logic [2:0]            req;
   logic                  gnt_any;
   logic [1:0]            gnt_id;
   logic                  accept;
   logic                  unused_addr_bits;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      end
      return merged;
   endfunction

   assign req = {wvalid, load_a_valid, fetch_addr_valid};

   // Byte-offset bits and bits above the SRAM range alias by design.
   assign unused_addr_bits = ^{fetch_addr[XLEN-1:ADDR_WIDTH+2], fetch_addr[1:0],
                               load_a_addr[XLEN-1:ADDR_WIDTH+2], load_a_addr[1:0],
                               waddr[XLEN-1:ADDR_WIDTH+2], waddr[1:0]};

`ifdef SRAM_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt_any = |req;
      gnt_id  = REQ_FETCH;
      if (req[REQ_STORE]) begin
         gnt_id = REQ_STORE;
      end else if (req[REQ_LOAD]) begin
         gnt_id = REQ_LOAD;
      end
   end
`else
   logic [1:0] ptr_q, ptr_d;

   // Search starts one past the last granted requester.
   always_comb begin
      logic [1:0] cand;
      gnt_any = 1'b0;
      gnt_id  = REQ_FETCH;
      cand    = ptr_q;
      for (int i = 0; i < 3; i++) begin
         cand = (cand == REQ_STORE) ? REQ_FETCH : cand + 2'd1;
         if (!gnt_any && req[cand]) begin
            gnt_any = 1'b1;
            gnt_id  = cand;
         end
      end
   end

   always_comb begin
      ptr_d = accept ? gnt_id : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr_q <= REQ_STORE;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   always_comb begin
      fetch_addr_ready = 1'b0;
      load_a_ready     = 1'b0;
      wready           = 1'b0;
      sram_we          = 1'b0;
      sram_addr        = '0;
      sram_wdata       = wdata;
      state_d          = state_q;
      fetch_vld_d      = 1'b0;
      load_vld_d       = 1'b0;
      rmw_addr_d       = rmw_addr_q;
      rmw_wdata_d      = rmw_wdata_q;
      rmw_strb_d       = rmw_strb_q;
      accept           = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               accept = 1'b1;
               case (gnt_id)
                  REQ_FETCH: begin
                     fetch_addr_ready = 1'b1;
                     sram_addr        = fetch_addr[ADDR_WIDTH+1:2];
                     fetch_vld_d      = 1'b1;
                  end
                  REQ_LOAD: begin
                     load_a_ready = 1'b1;
                     sram_addr    = load_a_addr[ADDR_WIDTH+1:2];
                     load_vld_d   = 1'b1;
                  end
                  default: begin
                     wready    = 1'b1;
                     sram_addr = waddr[ADDR_WIDTH+1:2];
                     if (wstrb == 4'hF) begin
                        sram_we = 1'b1;
                     end else if (wstrb != 4'h0) begin
                        // The read issued now returns the old word for the merge next cycle.
                        rmw_addr_d  = waddr[ADDR_WIDTH+1:2];
                        rmw_wdata_d = wdata;
                        rmw_strb_d  = wstrb;
                        state_d     = RMW_WR;
                     end
                  end
               endcase
            end
         end
         default: begin
            sram_we    = 1'b1;
            sram_addr  = rmw_addr_q;
            sram_wdata = merge_bytes(sram_rdata, rmw_wdata_q, rmw_strb_q);
            state_d    = IDLE;
         end
      endcase
      if (!rstn) begin
         fetch_addr_ready = 1'b0;
         load_a_ready     = 1'b0;
         wready           = 1'b0;
         sram_we          = 1'b0;
         accept           = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         fetch_vld_q <= 1'b0;
         load_vld_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_vld_q <= fetch_vld_d;
         load_vld_q  <= load_vld_d;
      end
   end

   always_ff @(posedge clk) begin
      rmw_addr_q  <= rmw_addr_d;
      rmw_wdata_q <= rmw_wdata_d;
      rmw_strb_q  <= rmw_strb_d;
   end

   // Responses due while reset is held are suppressed.
   assign fetch_data_valid = fetch_vld_q & rstn;
   assign load_d_valid     = load_vld_q & rstn;
   assign fetch_data       = sram_rdata;
   assign load_d_data      = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM model, table-driven handshake vectors and a response scoreboard.
// Build with SRAM_ARB_FIXED_PRIO_EN defined to exercise the fixed-priority arbitration rows.
module tb_sram_port_arbiter;

   localparam bit H = 1'b1;
   localparam bit L = 1'b0;

   logic        clk;
   logic        rstn;
   logic        fetch_addr_valid, fetch_addr_ready, fetch_data_valid;
   logic [63:0] fetch_addr;
   logic [31:0] fetch_data;
   logic        load_a_valid, load_a_ready, load_d_valid;
   logic [63:0] load_a_addr;
   logic [31:0] load_d_data;
   logic        wvalid, wready;
   logic [63:0] waddr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        sram_we;
   logic [19:0] sram_addr;
   logic [31:0] sram_wdata, sram_rdata;

   sram_port_arbiter #(.XLEN(64), .ADDR_WIDTH(20)) dut (
      .clk(clk), .rstn(rstn),
      .fetch_addr_valid(fetch_addr_valid), .fetch_addr_ready(fetch_addr_ready),
      .fetch_addr(fetch_addr), .fetch_data_valid(fetch_data_valid), .fetch_data(fetch_data),
      .load_a_valid(load_a_valid), .load_a_ready(load_a_ready), .load_a_addr(load_a_addr),
      .load_d_valid(load_d_valid), .load_d_data(load_d_data),
      .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
      .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: 1-cycle read latency, plus a backdoor write port for preloading.
   logic [31:0] mem [0:255];
   logic        bd_we;
   logic [7:0]  bd_idx;
   logic [31:0] bd_data;

   always @(posedge clk) begin
      if (bd_we) mem[bd_idx] <= bd_data;
      else if (sram_we) mem[sram_addr[7:0]] <= sram_wdata;
      sram_rdata <= mem[sram_addr[7:0]];
   end

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
      return r;
   endfunction

   // Reference memory and response scoreboard.
   typedef struct {
      logic        kind;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic [31:0] ref_mem [0:255];
   exp_t        sbq [$];
   exp_t        mon_e;
   logic        pend = 1'b0;
   logic [7:0]  pend_idx;
   logic [31:0] pend_wd;
   logic [3:0]  pend_ws;

   always @(negedge clk) begin
      if (!rstn) begin
         sbq.delete();
         pend = 1'b0;
      end else begin
         if (pend) begin
            ref_mem[pend_idx] = merge(ref_mem[pend_idx], pend_wd, pend_ws);
            pend = 1'b0;
         end
         if (fetch_data_valid || load_d_valid) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_unexpected: got fetch_v=%0b load_v=%0b, required none", fetch_data_valid, load_d_valid);
            end else begin
               mon_e = sbq.pop_front();
               chk("resp_kind", 64'({load_d_valid, fetch_data_valid}), mon_e.kind ? 64'h2 : 64'h1);
               chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
               chk("resp_data", 64'(mon_e.kind ? load_d_data : fetch_data), 64'(mon_e.data));
            end
         end
         if (fetch_addr_valid && fetch_addr_ready)
            sbq.push_back('{1'b0, ref_mem[fetch_addr[9:2]], cyc + 1});
         if (load_a_valid && load_a_ready)
            sbq.push_back('{1'b1, ref_mem[load_a_addr[9:2]], cyc + 1});
         if (wvalid && wready) begin
            if (wstrb == 4'hF) begin
               ref_mem[waddr[9:2]] = wdata;
            end else if (wstrb != 4'h0) begin
               pend     = 1'b1;
               pend_idx = waddr[9:2];
               pend_wd  = wdata;
               pend_ws  = wstrb;
            end
         end
      end
   end

   typedef struct {
      logic        fv, lv, wv;
      logic [63:0] fa, la, wa;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic        efr, elr, ewr, ewe;
      logic        chk_addr;
      logic [19:0] eaddr;
      logic [31:0] ewd;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t mk(input logic fv, input logic lv, input logic wv,
                               input logic [63:0] fa, input logic [63:0] la, input logic [63:0] wa,
                               input logic [31:0] wd, input logic [3:0] ws,
                               input logic efr, input logic elr, input logic ewr, input logic ewe,
                               input logic ca, input logic [19:0] eaddr, input logic [31:0] ewd);
      vec_t v;
      v.fv = fv; v.lv = lv; v.wv = wv; v.fa = fa; v.la = la; v.wa = wa; v.wd = wd; v.ws = ws;
      v.efr = efr; v.elr = elr; v.ewr = ewr; v.ewe = ewe; v.chk_addr = ca; v.eaddr = eaddr; v.ewd = ewd;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_tbl(input string tag);
      foreach (tbl[i]) begin
         fetch_addr_valid = tbl[i].fv; fetch_addr = tbl[i].fa;
         load_a_valid     = tbl[i].lv; load_a_addr = tbl[i].la;
         wvalid = tbl[i].wv; waddr = tbl[i].wa; wdata = tbl[i].wd; wstrb = tbl[i].ws;
         @(negedge clk);
         chk($sformatf("%s%0d_rdy_we", tag, i),
             64'({fetch_addr_ready, load_a_ready, wready, sram_we}),
             64'({tbl[i].efr, tbl[i].elr, tbl[i].ewr, tbl[i].ewe}));
         if (tbl[i].chk_addr) begin
            chk($sformatf("%s%0d_addr", tag, i), 64'(sram_addr), 64'(tbl[i].eaddr));
            if (tbl[i].ewe) chk($sformatf("%s%0d_wdata", tag, i), 64'(sram_wdata), 64'(tbl[i].ewd));
         end
         step();
      end
      tbl.delete();
   endtask

   task automatic idle_inputs();
      fetch_addr_valid = 1'b0; load_a_valid = 1'b0; wvalid = 1'b0;
      fetch_addr = '0; load_a_addr = '0; waddr = '0; wdata = '0; wstrb = '0;
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] d);
      bd_we = 1'b1; bd_idx = idx; bd_data = d;
      ref_mem[idx] = d;
      step();
      bd_we = 1'b0;
   endtask

   initial begin
      bd_we = 1'b0; bd_idx = '0; bd_data = '0;
      idle_inputs();
      rstn = 1'b0;
      // Reset with every requester asserting: all readies, valids and sram_we held low.
      fetch_addr_valid = 1'b1; load_a_valid = 1'b1; wvalid = 1'b1; wstrb = 4'hF;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("reset_outputs", 64'({fetch_addr_ready, load_a_ready, wready, sram_we, fetch_data_valid, load_d_valid}), 64'h0);
         step();
      end
      idle_inputs();
      preload(8'd0, 32'h0000_00A0);
      preload(8'd1, 32'h0000_00A1);
      preload(8'd2, 32'h0000_00A2);
      preload(8'd4, 32'h1122_3344);
      rstn = 1'b1;

      // Back-to-back fetches, then an aliased address (upper and byte-offset bits ignored).
      tbl.push_back(mk(H, L, L, 64'h0, 64'h0, 64'h0, 32'h0, 4'h0, H, L, L, L, H, 20'h0, 32'h0));
      tbl.push_back(mk(H, L, L, 64'h4, 64'h0, 64'h0, 32'h0, 4'h0, H, L, L, L, H, 20'h1, 32'h0));
      tbl.push_back(mk(H, L, L, 64'h8, 64'h0, 64'h0, 32'h0, 4'h0, H, L, L, L, H, 20'h2, 32'h0));
      tbl.push_back(mk(H, L, L, 64'h0000_0001_0040_0007, 64'h0, 64'h0, 32'h0, 4'h0, H, L, L, L, H, 20'h1, 32'h0));
      tbl.push_back(mk(L, L, L, 64'h0, 64'h0, 64'h0, 32'h0, 4'h0, L, L, L, L, L, 20'h0, 32'h0));
      run_tbl("fetch");

      rstn = 1'b0;
      step();
      rstn = 1'b1;

      // All three requesters held valid with full-word stores.
`ifdef SRAM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 10; i++)
         tbl.push_back(mk(H, H, H, 64'h0, 64'h4, 64'h20, 32'hC0DE_0000 + 32'(i), 4'hF, L, L, H, H, H, 20'h8, 32'hC0DE_0000 + 32'(i)));
      tbl.push_back(mk(H, L, L, 64'h0, 64'h4, 64'h20, 32'h0, 4'hF, H, L, L, L, H, 20'h0, 32'h0));
`else
      for (int i = 0; i < 2; i++) begin
         tbl.push_back(mk(H, H, H, 64'h0, 64'h4, 64'h20, 32'hC0DE_0000, 4'hF, H, L, L, L, H, 20'h0, 32'h0));
         tbl.push_back(mk(H, H, H, 64'h0, 64'h4, 64'h20, 32'hC0DE_0000, 4'hF, L, H, L, L, H, 20'h1, 32'h0));
         tbl.push_back(mk(H, H, H, 64'h0, 64'h4, 64'h20, 32'hC0DE_0000 + 32'(i), 4'hF, L, L, H, H, H, 20'h8, 32'hC0DE_0000 + 32'(i)));
      end
`endif
      tbl.push_back(mk(L, L, L, 64'h0, 64'h0, 64'h0, 32'h0, 4'h0, L, L, L, L, L, 20'h0, 32'h0));
      run_tbl("arb");

      // Partial store RMW, read-back, full store then immediate read, and an empty-strobe store.
      tbl.push_back(mk(L, L, H, 64'h0, 64'h0, 64'h10, 32'h0000_AB00, 4'b0010, L, L, H, L, H, 20'h4, 32'h0));
      tbl.push_back(mk(H, L, L, 64'h0, 64'h0, 64'h0, 32'h0, 4'h0, L, L, L, H, H, 20'h4, 32'h1122_AB44));
      tbl.push_back(mk(L, H, L, 64'h0, 64'h10, 64'h0, 32'h0, 4'h0, L, H, L, L, H, 20'h4, 32'h0));
      tbl.push_back(mk(L, L, H, 64'h0, 64'h0, 64'h8, 32'h5555_AAAA, 4'hF, L, L, H, H, H, 20'h2, 32'h5555_AAAA));
      tbl.push_back(mk(L, H, L, 64'h0, 64'h8, 64'h0, 32'h0, 4'h0, L, H, L, L, H, 20'h2, 32'h0));
      tbl.push_back(mk(L, L, H, 64'h0, 64'h0, 64'h0, 32'hFFFF_FFFF, 4'h0, L, L, H, L, L, 20'h0, 32'h0));
      tbl.push_back(mk(L, H, L, 64'h0, 64'h0, 64'h0, 32'h0, 4'h0, L, H, L, L, H, 20'h0, 32'h0));
      tbl.push_back(mk(L, L, L, 64'h0, 64'h0, 64'h0, 32'h0, 4'h0, L, L, L, L, L, 20'h0, 32'h0));
      run_tbl("st");
      chk("wstrb0_mem_unchanged", 64'(mem[0]), 64'h0000_00A0);

      // A fetch response due in the cycle reset asserts is suppressed.
      fetch_addr_valid = 1'b1; fetch_addr = 64'h4;
      @(negedge clk);
      chk("pre_reset_fetch_rdy", 64'(fetch_addr_ready), 64'h1);
      step();
      fetch_addr_valid = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      chk("reset_resp_suppressed", 64'({fetch_data_valid, load_d_valid}), 64'h0);
      step();
      rstn = 1'b1;

      // Reset during the write cycle of a partial store drops the write.
      preload(8'd4, 32'h1122_3344);
      wvalid = 1'b1; waddr = 64'h10; wdata = 32'h0000_AB00; wstrb = 4'b0010;
      @(negedge clk);
      chk("rmw_accept", 64'(wready), 64'h1);
      step();
      wvalid = 1'b0;
      rstn = 1'b0;
      fetch_addr_valid = 1'b1; load_a_valid = 1'b1;
      @(negedge clk);
      chk("rmw_reset_outputs", 64'({fetch_addr_ready, load_a_ready, wready, sram_we, fetch_data_valid, load_d_valid}), 64'h0);
      step();
      rstn = 1'b1;
      idle_inputs();
      @(negedge clk);
      chk("rmw_reset_mem", 64'(mem[4]), 64'h1122_3344);
      chk("rmw_reset_idle_we", 64'(sram_we), 64'h0);
      step();
      tbl.push_back(mk(L, H, L, 64'h0, 64'h10, 64'h0, 32'h0, 4'h0, L, H, L, L, H, 20'h4, 32'h0));
      tbl.push_back(mk(L, L, L, 64'h0, 64'h0, 64'h0, 32'h0, 4'h0, L, L, L, L, L, 20'h0, 32'h0));
      tbl.push_back(mk(L, L, L, 64'h0, 64'h0, 64'h0, 32'h0, 4'h0, L, L, L, L, L, 20'h0, 32'h0));
      run_tbl("post");

      chk("scoreboard_drained", 64'(sbq.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port, 1-cycle-latency sram1rw instance between three requesters: instruction fetch, dcache load, and dcache store.
- Sits in system between core and the SRAM.
- Serialises all accesses.
- Returns read data with fixed 1-cycle latency.
- Implements sub-word stores as a 2-cycle read-modify-write, because the SRAM has no byte enables.

Parameters:
XLEN, 64, width of fetch/load/store byte addresses
ADDR_WIDTH, 20, SRAM word-address width; SRAM word index = addr[ADDR_WIDTH+1:2]

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
fetch_addr_valid  in  1  fetch request valid
fetch_addr_ready  out  1  fetch request accepted this cycle
fetch_addr  in  XLEN  fetch byte address
fetch_data_valid  out  1  fetch response valid
fetch_data  out  32  fetch response word
load_a_valid  in  1  load request valid
load_a_ready  out  1  load request accepted
load_a_addr  in  XLEN  load byte address
load_d_valid  out  1  load response valid
load_d_data  out  32  load response word
wvalid  in  1  store request valid
wready  out  1  store request accepted
waddr  in  XLEN  store byte address
wdata  in  32  store data, lane-aligned
wstrb  in  4  store byte enables
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_WIDTH  SRAM word address
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data, valid 1 cycle after a read

Behaviour:

Reset:
- rstn is synchronous and active-low; clock is clk.
- While rstn=0, all of the following are 0: ready outputs, response valids, sram_we.
- State returns to IDLE; round-robin pointer = STORE, so FETCH has highest priority first.
- fetch_data/load_d_data are don't-care while their valid is 0.

States:
- IDLE: arbitrate among valid requesters.
- RMW_WR: second cycle of a partial store.

Handshake and arbitration:
- Accept = valid && ready.
- Ready is combinational and goes only to the single granted requester; the other readies are 0.
- Valid/addr/data must stay stable until accepted.
- Round-robin order is FETCH(0) -> LOAD(1) -> STORE(2).
- Search starts at pointer+1.
- Pointer updates to the granted requester only on accept.
- If nothing is valid, the pointer holds and the SRAM stays idle (sram_we=0).

IDLE, fetch/load grant:
- sram_we=0; sram_addr = word index of the request.
- Next cycle, the matching response valid = 1 and data = sram_rdata.
- No response back-pressure; the requester must sink it.
- Back-to-back reads at 1 per cycle are supported.

IDLE, store grant with wstrb=4'hF:
- sram_we=1, sram_wdata=wdata, same cycle.
- Done in 1 cycle.

IDLE, store grant with wstrb=0:
- Accepted; no SRAM access.

IDLE, store grant with partial wstrb:
- wready=1.
- Latch address, wdata, wstrb.
- Issue SRAM read.
- Go to RMW_WR.

RMW_WR:
- All readies = 0.
- sram_we=1, sram_addr=latched address.
- sram_wdata byte i = wstrb[i] ? wdata byte i : sram_rdata byte i.
- Next state: IDLE.
- The arbiter pointer was already updated at accept.

Address handling:
- Bits above ADDR_WIDTH+1 are ignored (aliasing).
- Bits [1:0] are ignored.

Ordering and hazards:
- A read in the cycle after a write to the same word returns the new data (SRAM write-first timing by serialisation).
- The arbiter guarantees at most one SRAM access per cycle.

Reset mid-RMW:
- The pending write is dropped (sram_we=0); memory is unchanged.
- Any response due the cycle after reset asserts is suppressed.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority STORE > LOAD > FETCH; the pointer is unused; starvation is permitted.
- Undefined: round-robin as above.
- The port list is identical in both builds.

Test Plan:
1. Preload words 0x0/0x4/0x8 = 0xA0/0xA1/0xA2. Fetch valid on all three consecutive cycles -> fetch_addr_ready=1 each cycle; fetch_data_valid=1 on the following 3 cycles with 0xA0, 0xA1, 0xA2.
2. From reset, fetch, load and full store (wstrb=F) all held valid -> grants cycle by cycle are FETCH, LOAD, STORE, FETCH, ...; exactly one ready per cycle; sram_we=1 only in STORE cycles.
3. Word 0x10 = 0x11223344. Store waddr=0x10, wdata=0x0000AB00, wstrb=4'b0010 -> wready for 1 cycle; next cycle all readies 0 with sram_we=1, sram_wdata=0x1122AB44; a subsequent load of 0x10 returns 0x1122AB44.
4. Partial store as in 3, rstn=0 during RMW_WR -> sram_we=0, word 0x10 stays 0x11223344; after reset all valid/ready outputs are 0 for the reset cycle.
5. Store with wstrb=0 -> wready=1 for one cycle, sram_we stays 0, memory unchanged.
6. SRAM_ARB_FIXED_PRIO_EN defined, all three requesters held valid for 10 cycles -> wready=1 every cycle; load/fetch ready stay 0; fetch is granted the first cycle wvalid/load_a_valid drop.
